// File: rtl/fft_axis_unloader.sv
// ---------------------------------------------------------------------------
// fft_axis_unloader
//
// Purpose:
//   Holds one FFT frame of N = 2**N_LOG2 complex samples in a RAM that the
//   butterfly datapath fills two results at a time. On request, the frame is
//   streamed out over an AXI4-Stream master port, either in natural address
//   order or in bit-reversed address order.
//
// Parameters:
//   DATA_W  - sample width ({imag, real}, each DATA_W/2 bits)
//   N_LOG2  - log2 of the FFT point count (also the RAM depth)
//
// Ports:
//   clk             single clock, everything on the rising edge
//   rst             asynchronous reset, active-high
//   wr_en           write both butterfly results this cycle
//   wr_x1, wr_x2    butterfly results
//   wr_idx1/2       RAM addresses for wr_x1 / wr_x2
//   bitrev_mode     1 = unload in bit-reversed order, 0 = natural order
//   unload_start    request to stream one frame
//   busy            an unload is in progress
//   unload_done     one-cycle pulse at the end of the frame
//   wr_drop         one-cycle pulse when a write was discarded
//   m_axis_*        AXI4-Stream master (tuser marks beat 0, tlast beat N-1)
// ---------------------------------------------------------------------------
module fft_axis_unloader #(
    parameter int DATA_W = 64,
    parameter int N_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_x1,
    input  logic [DATA_W-1:0] wr_x2,
    input  logic [N_LOG2-1:0] wr_idx1,
    input  logic [N_LOG2-1:0] wr_idx2,
    input  logic              bitrev_mode,
    input  logic              unload_start,
    output logic              busy,
    output logic              unload_done,
    output logic              wr_drop,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser
);

    localparam int N = 1 << N_LOG2;

    // Beat counter limits, sized one bit wider than the address so that the
    // count N is representable and the counter never wraps inside a frame.
    localparam logic [N_LOG2:0] BEAT_FIRST = '0;
    localparam logic [N_LOG2:0] BEAT_LAST  = (N_LOG2+1)'(N - 1);
    localparam logic [N_LOG2:0] BEAT_END   = (N_LOG2+1)'(N);
    localparam logic [N_LOG2:0] BEAT_ONE   = (N_LOG2+1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [N_LOG2:0]   beatCnt_q,   beatCnt_d;
    logic              bitrev_q,    bitrev_d;
    logic              outValid_q,  outValid_d;
    logic [DATA_W-1:0] outData_q;
    logic              outFirst_q;
    logic              outLast_q;
    logic              wrDrop_q;

    // Frame storage; deliberately not reset so a frame survives a reset.
    logic [DATA_W-1:0] mem [N];

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic              startAccept;
    logic              ramWrite;
    logic              handshake;
    logic              lastHandshake;
    logic              rdEn;
    logic [N_LOG2-1:0] natAddr;
    logic [N_LOG2-1:0] revAddr;
    logic [N_LOG2-1:0] rdAddr;

    assign startAccept   = (state_q == ST_IDLE) && unload_start;
    assign ramWrite      = (state_q == ST_IDLE) && wr_en;
    assign handshake     = outValid_q && m_axis_tready;
    assign lastHandshake = handshake && outLast_q;

    // The output register doubles as the single-entry prefetch stage: a new
    // RAM read is launched whenever that register is empty or is being
    // drained this cycle, which gives one beat per cycle under tready=1.
    // The first read happens the cycle after the start is accepted, so a
    // write performed in the start cycle is already visible in the RAM.
    assign rdEn = (state_q == ST_STREAM) && (beatCnt_q != BEAT_END) &&
                  (!outValid_q || m_axis_tready);

    assign natAddr = beatCnt_q[N_LOG2-1:0];

    // Mirror the address bits for bit-reversed unloading.
    always_comb begin
        revAddr = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            revAddr[i] = natAddr[N_LOG2-1-i];
        end
    end

    assign rdAddr = bitrev_q ? revAddr : natAddr;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beatCnt_d  = beatCnt_q;
        bitrev_d   = bitrev_q;
        outValid_d = outValid_q;

        case (state_q)
            ST_IDLE: begin
                if (unload_start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (lastHandshake) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Order mode is sampled once per frame so the caller may change
        // bitrev_mode freely while a frame is in flight.
        if (startAccept) begin
            beatCnt_d = BEAT_FIRST;
            bitrev_d  = bitrev_mode;
        end else if (rdEn) begin
            beatCnt_d = beatCnt_q + BEAT_ONE;
        end

        if (rdEn) begin
            outValid_d = 1'b1;
        end else if (handshake) begin
            outValid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beatCnt_q  <= '0;
            bitrev_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outFirst_q <= 1'b0;
            outLast_q  <= 1'b0;
            wrDrop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beatCnt_q  <= beatCnt_d;
            bitrev_q   <= bitrev_d;
            outValid_q <= outValid_d;
            wrDrop_q   <= wr_en && (state_q != ST_IDLE);
            // Frame-position flags travel with the data they belong to.
            if (rdEn) begin
                outData_q  <= mem[rdAddr];
                outFirst_q <= (beatCnt_q == BEAT_FIRST);
                outLast_q  <= (beatCnt_q == BEAT_LAST);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Dual write port RAM. Port 2 is written first so that when both ports
    // hit the same address the later assignment, wr_x1, is what is kept.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            mem[wr_idx2] <= wr_x2;
            mem[wr_idx1] <= wr_x1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy          = (state_q != ST_IDLE);
    assign unload_done   = (state_q == ST_DONE);
    assign wr_drop       = wrDrop_q;
    assign m_axis_tvalid = outValid_q;
    assign m_axis_tdata  = outValid_q ? outData_q : '0;
    assign m_axis_tlast  = outValid_q && outLast_q;
    assign m_axis_tuser  = outValid_q && outFirst_q;

endmodule

// File: tb/tb_fft_axis_unloader.sv
// ---------------------------------------------------------------------------
// tb_fft_axis_unloader
//
// Self-checking bench for fft_axis_unloader at N_LOG2=3, DATA_W=64.
// A small array model of the frame RAM supplies the expected beat sequence;
// the directed table carries the expected order of beats for a known frame.
// ---------------------------------------------------------------------------
module tb_fft_axis_unloader;

    localparam int DATA_W = 64;
    localparam int N_LOG2 = 3;
    localparam int N      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_x1 = '0;
    logic [DATA_W-1:0] wr_x2 = '0;
    logic [N_LOG2-1:0] wr_idx1 = '0;
    logic [N_LOG2-1:0] wr_idx2 = '0;
    logic              bitrev_mode = 1'b0;
    logic              unload_start = 1'b0;
    logic              busy;
    logic              unload_done;
    logic              wr_drop;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tuser;

    fft_axis_unloader #(
        .DATA_W(DATA_W),
        .N_LOG2(N_LOG2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_x1        (wr_x1),
        .wr_x2        (wr_x2),
        .wr_idx1      (wr_idx1),
        .wr_idx2      (wr_idx2),
        .bitrev_mode  (bitrev_mode),
        .unload_start (unload_start),
        .busy         (busy),
        .unload_done  (unload_done),
        .wr_drop      (wr_drop),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] modelMem [N];
    logic [DATA_W-1:0] expData  [N];

    // order holds, nibble k, the RAM index expected on beat k.
    typedef struct {
        bit          br;
        int          pct;
        logic [31:0] order;
    } vec_t;

    vec_t tbl [4];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int bitrev3(input int k);
        int r;
        r = 0;
        for (int b = 0; b < N_LOG2; b++) begin
            r = r * 2 + ((k >> b) & 1);
        end
        return r;
    endfunction

    task automatic loadModelExpect(input bit br);
        for (int k = 0; k < N; k++) begin
            expData[k] = modelMem[br ? bitrev3(k) : k];
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},   busy, 0);
        checkOutput({tag, "_done"},   unload_done, 0);
        checkOutput({tag, "_drop"},   wr_drop, 0);
        checkOutput({tag, "_tvalid"}, m_axis_tvalid, 0);
        checkOutput({tag, "_tdata"},  m_axis_tdata, 0);
        checkOutput({tag, "_tlast"},  m_axis_tlast, 0);
        checkOutput({tag, "_tuser"},  m_axis_tuser, 0);
    endtask

    task automatic writePair(input logic [2:0] i1, input logic [63:0] x1,
                             input logic [2:0] i2, input logic [63:0] x2);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_idx1 = i1;
        wr_x1   = x1;
        wr_idx2 = i2;
        wr_x2   = x2;
        modelMem[i2] = x2;
        modelMem[i1] = x1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Streams one frame and compares every beat against expData.
    task automatic applyStimulus(input bit br, input int pct, input bit intrude,
                                 input int abortAt, input bit startWr,
                                 input logic [2:0] swIdx, input logic [63:0] swData);
        int k;
        bit stalled;
        bit done;
        logic [63:0] heldData;
        logic heldLast;
        logic heldUser;
        k = 0;
        stalled = 0;
        done = 0;
        heldData = '0;
        heldLast = 0;
        heldUser = 0;

        @(posedge clk); #1;
        unload_start  = 1'b1;
        bitrev_mode   = br;
        m_axis_tready = 1'b0;
        if (startWr) begin
            wr_en   = 1'b1;
            wr_idx1 = swIdx;
            wr_idx2 = swIdx;
            wr_x1   = swData;
            wr_x2   = swData;
        end
        @(negedge clk);
        checkOutput("busy_start_cycle", busy, 0);

        for (int c = 1; c <= 200 && !done; c++) begin
            @(posedge clk); #1;
            unload_start  = (intrude && c == 4);
            wr_en         = (intrude && c == 4);
            bitrev_mode   = ~br;
            wr_idx1       = 3'd2;
            wr_idx2       = 3'd2;
            wr_x1         = 64'hDEAD;
            wr_x2         = 64'hBEEF;
            m_axis_tready = ($urandom_range(99) < pct);
            @(negedge clk);

            if (c == 1) begin
                checkOutput("tvalid_cycle1", m_axis_tvalid, 0);
                checkOutput("busy_cycle1", busy, 1);
            end
            if (c == 2) begin
                checkOutput("tvalid_cycle2", m_axis_tvalid, 1);
            end
            if (intrude && c == 5) begin
                checkOutput("wr_drop_pulse", wr_drop, 1);
            end
            if (stalled) begin
                checkOutput("stall_tvalid", m_axis_tvalid, 1);
                checkOutput("stall_tdata", m_axis_tdata, heldData);
                checkOutput("stall_tlast", m_axis_tlast, heldLast);
                checkOutput("stall_tuser", m_axis_tuser, heldUser);
            end

            if (m_axis_tvalid && m_axis_tready) begin
                checkOutput("beat_tdata", m_axis_tdata, expData[k]);
                checkOutput("beat_tuser", m_axis_tuser, (k == 0));
                checkOutput("beat_tlast", m_axis_tlast, (k == N - 1));
                k++;
                stalled = 0;
                if (k == N) done = 1;
            end else begin
                stalled  = m_axis_tvalid;
                heldData = m_axis_tdata;
                heldLast = m_axis_tlast;
                heldUser = m_axis_tuser;
            end

            if (abortAt >= 0 && k == abortAt) begin
                #2;
                unload_start  = 1'b0;
                wr_en         = 1'b0;
                m_axis_tready = 1'b0;
                rst = 1'b1;
                #1;
                checkAllZero("abort");
                @(posedge clk); #1;
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    checkOutput("abort_no_done", unload_done, 0);
                    checkOutput("abort_idle_tvalid", m_axis_tvalid, 0);
                    @(posedge clk); #1;
                end
                return;
            end
        end

        wr_en        = 1'b0;
        unload_start = 1'b0;
        if (!done) begin
            checkOutput("frame_timeout_beats", k, N);
        end else begin
            @(posedge clk); #1;
            m_axis_tready = 1'b0;
            @(negedge clk);
            checkOutput("done_pulse", unload_done, 1);
            checkOutput("done_tvalid", m_axis_tvalid, 0);
            checkOutput("done_tdata", m_axis_tdata, 0);
            checkOutput("done_busy", busy, 1);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("after_done_busy", busy, 0);
            checkOutput("after_done_pulse", unload_done, 0);
        end
    endtask

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{br: 1'b0, pct: 100, order: 32'h76543210};
        tbl[1] = '{br: 1'b1, pct: 100, order: 32'h73516240};
        tbl[2] = '{br: 1'b0, pct: 50,  order: 32'h76543210};
        tbl[3] = '{br: 1'b1, pct: 50,  order: 32'h73516240};

        // Reset state
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill RAM[i] = i + 0x100 in pairs (i, i+4)
        for (int i = 0; i < 4; i++) begin
            writePair(3'(i), 64'h100 + 64'(i), 3'(i + 4), 64'h100 + 64'(i + 4));
        end

        // Directed table: natural / bit-reversed, free-flowing / stalled
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < N; k++) begin
                expData[k] = 64'h100 + 64'(tbl[v].order[4*k +: 4]);
            end
            applyStimulus(tbl[v].br, tbl[v].pct, 1'b0, -1, 1'b0, 3'd0, 64'd0);
        end

        // Write and start request while streaming are both ignored
        loadModelExpect(1'b0);
        applyStimulus(1'b0, 100, 1'b1, -1, 1'b0, 3'd0, 64'd0);
        loadModelExpect(1'b0);
        applyStimulus(1'b0, 100, 1'b0, -1, 1'b0, 3'd0, 64'd0);

        // Reset after beat 3, then a fresh frame from beat 0
        loadModelExpect(1'b0);
        applyStimulus(1'b0, 100, 1'b0, 4, 1'b0, 3'd0, 64'd0);
        applyStimulus(1'b0, 100, 1'b0, -1, 1'b0, 3'd0, 64'd0);

        // Write in the same cycle as the start is visible in the frame
        modelMem[6] = 64'h666;
        loadModelExpect(1'b0);
        applyStimulus(1'b0, 100, 1'b0, -1, 1'b1, 3'd6, 64'h666);

        // Both write ports on one address: port 1 wins
        writePair(3'd5, 64'hAA, 3'd5, 64'hBB);
        loadModelExpect(1'b0);
        applyStimulus(1'b0, 100, 1'b0, -1, 1'b0, 3'd0, 64'd0);

        // Randomized writes, order mode and back-pressure
        for (int it = 0; it < 15; it++) begin
            bit br;
            bit sw;
            logic [2:0] swIdx;
            logic [63:0] swData;
            for (int j = 0; j < 3; j++) begin
                writePair(3'($urandom_range(7)), {$urandom, $urandom},
                          3'($urandom_range(7)), {$urandom, $urandom});
            end
            br     = 1'($urandom_range(1));
            sw     = 1'($urandom_range(1));
            swIdx  = 3'($urandom_range(7));
            swData = {$urandom, $urandom};
            if (sw) modelMem[swIdx] = swData;
            loadModelExpect(br);
            applyStimulus(br, 30 + $urandom_range(70), 1'b0, -1, sw, swIdx, swData);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
